// File: rtl/ysyx_22041207_mem_arb.sv
// +--------------------------------------------------------------------------+
// | ysyx_22041207_mem_arb : fetch/data arbiter onto one single-outstanding   |
// |                         memory port, with starvation guard for fetch.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_22041207_mem_arb #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        stall_if,
  input  logic        me_req,
  input  logic        me_wen,
  input  logic [63:0] me_addr,
  input  logic [63:0] me_wdata,
  input  logic [7:0]  me_wmask,
  output logic        me_gnt,
  output logic        me_rvalid,
  output logic [63:0] me_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int            C_CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [C_CW-1:0] C_STARVE_LIM = C_CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    ME_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [C_CW-1:0]   starve_q, starve_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wen_q, mem_wen_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_wmask_q, mem_wmask_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              me_rvalid_q, me_rvalid_d;
  logic [63:0]       me_rdata_q, me_rdata_d;

  logic              w_idle;
  logic              w_force_if;
  logic              w_gnt_me;
  logic              w_gnt_if;

  // A flushed fetch cannot use a forced grant, so ME keeps the slot then.
  always_comb begin
    w_idle     = (state_q == IDLE);
    w_force_if = if_req & ~if_flush & (starve_q == C_STARVE_LIM);
    w_gnt_me   = rst_n & w_idle & me_req & ~w_force_if;
    w_gnt_if   = rst_n & w_idle & if_req & ~if_flush & ~w_gnt_me;
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    me_rvalid_d = 1'b0;
    me_rdata_d  = me_rdata_q;

    case (state_q)
      IDLE: begin
        if (w_gnt_me) begin
          state_d     = ME_WAIT;
          mem_req_d   = 1'b1;
          mem_wen_d   = me_wen;
          mem_addr_d  = me_addr;
          mem_wdata_d = me_wdata;
          mem_wmask_d = me_wmask;
        end else if (w_gnt_if) begin
          state_d     = IF_WAIT;
          mem_req_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 64'd0;
          mem_wmask_d = 8'd0;
        end
      end
      IF_WAIT: begin
        if (if_flush) begin
          drop_d = 1'b1;
        end
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A cancelled fetch completes on the bus but leaves if_rdata untouched.
          if (!(drop_q || if_flush)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata[31:0];
          end
        end
      end
      ME_WAIT: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          me_rvalid_d = 1'b1;
          me_rdata_d  = mem_rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase

    if (w_gnt_if) begin
      starve_d = '0;
    end else if (w_gnt_me && if_req && (starve_q != C_STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_wmask_q <= 8'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      me_rvalid_q <= 1'b0;
      me_rdata_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      me_rvalid_q <= me_rvalid_d;
      me_rdata_q  <= me_rdata_d;
    end
  end

  assign if_gnt    = w_gnt_if;
  assign me_gnt    = w_gnt_me;
  assign stall_if  = if_req & ~w_gnt_if & ~if_flush;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign me_rvalid = me_rvalid_q;
  assign me_rdata  = me_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041207_mem_arb.sv
// +--------------------------------------------------------------------------+
// | tb_ysyx_22041207_mem_arb : scoreboard bench for the fetch/data arbiter.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22041207_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        stall_if;
  logic        me_req;
  logic        me_wen;
  logic [63:0] me_addr;
  logic [63:0] me_wdata;
  logic [7:0]  me_wmask;
  logic        me_gnt;
  logic        me_rvalid;
  logic [63:0] me_rdata;
  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  typedef struct packed {
    logic        is_if;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_lat  = 0;
  int          wait_cnt = 0;
  bit          auto_ack = 1'b1;
  logic [63:0] rsp_data = 64'd0;

  ysyx_22041207_mem_arb #(.STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .stall_if  (stall_if),
    .me_req    (me_req),
    .me_wen    (me_wen),
    .me_addr   (me_addr),
    .me_wdata  (me_wdata),
    .me_wmask  (me_wmask),
    .me_gnt    (me_gnt),
    .me_rvalid (me_rvalid),
    .me_rdata  (me_rdata),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: ack ack_lat cycles after mem_req is first seen.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 64'd0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_ack) begin
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
          if (wait_cnt >= ack_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rsp_data;
            wait_cnt  = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_gnt === 1'b1 && me_gnt === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL dual_grant if_gnt=1 me_gnt=1 required at most one");
    end
    if (if_rvalid === 1'b1 || me_rvalid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid if_rvalid=%0b me_rvalid=%0b required none", if_rvalid, me_rvalid);
      end else begin
        e = sb.pop_front();
        if (if_rvalid === 1'b1) begin
          if (e.is_if !== 1'b1 || if_rdata !== e.data[31:0]) begin
            n_fail++;
            $display("FAIL if_response is_if=%0b if_rdata=%h required is_if=1 rdata=%h", e.is_if, if_rdata, e.data[31:0]);
          end
        end else begin
          if (e.is_if !== 1'b0 || me_rdata !== e.data) begin
            n_fail++;
            $display("FAIL me_response is_if=%0b me_rdata=%h required is_if=0 rdata=%h", e.is_if, me_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    for (int c = 0; c < 12 && sb.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = 64'd0; if_flush = 1'b0;
    me_req = 1'b0; me_wen = 1'b0; me_addr = 64'd0; me_wdata = 64'd0; me_wmask = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({if_gnt, me_gnt, if_rvalid, me_rvalid, mem_req, mem_wen, stall_if} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b required 0000000", {if_gnt, me_gnt, if_rvalid, me_rvalid, mem_req, mem_wen, stall_if});
    end
    n_checks++;
    if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_wmask !== 8'd0 || if_rdata !== 32'd0 || me_rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data addr=%h wdata=%h wmask=%h if_rdata=%h me_rdata=%h required all 0", mem_addr, mem_wdata, mem_wmask, if_rdata, me_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    int lat;
    ack_lat  = 2;
    rsp_data = 64'h00000013_00100093;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h80000000;
    sb.push_back('{is_if: 1'b1, data: rsp_data});
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1 || me_gnt !== 1'b0 || stall_if !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_grant if_gnt=%b me_gnt=%b stall_if=%b required 1 0 0", if_gnt, me_gnt, stall_if);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h80000000 || mem_wen !== 1'b0 || mem_wmask !== 8'd0) begin
      n_fail++;
      $display("FAIL fetch_mem req=%b addr=%h wen=%b wmask=%h required 1 80000000 0 00", mem_req, mem_addr, mem_wen, mem_wmask);
    end
    lat = -1;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (if_rvalid === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL fetch_latency rvalid_cycle=%0d required 4", lat);
    end
    drain("fetch");
  endtask

  task automatic test_contention();
    int       ng;
    logic [3:0] order;
    ack_lat  = 0;
    rsp_data = 64'h11223344_55667788;
    for (int i = 0; i < 3; i++) sb.push_back('{is_if: 1'b0, data: rsp_data});
    sb.push_back('{is_if: 1'b1, data: rsp_data});
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h80000400;
    me_req = 1'b1; me_wen = 1'b0; me_addr = 64'h80001000; me_wdata = 64'd0; me_wmask = 8'd0;
    ng = 0; order = 4'd0;
    for (int c = 0; c < 24 && ng < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_if !== ~if_gnt) begin
        n_fail++;
        $display("FAIL contention_stall cycle=%0d stall_if=%b if_gnt=%b required stall=~if_gnt", c, stall_if, if_gnt);
      end
      if (me_gnt === 1'b1) begin
        order[ng] = 1'b0; ng++;
      end else if (if_gnt === 1'b1) begin
        order[ng] = 1'b1; ng++;
      end
      if (ng < 4) @(posedge clk);
    end
    @(posedge clk); #1;
    if_req = 1'b0; me_req = 1'b0;
    n_checks++;
    if (ng != 4 || order !== 4'b1000) begin
      n_fail++;
      $display("FAIL contention_order grants=%0d order(lsb first,1=IF)=%b required 4 1000", ng, order);
    end
    drain("contention");
  endtask

  task automatic test_flush();
    int cnt;
    ack_lat  = 2;
    rsp_data = 64'h12345678_9ABCDEF0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h80000100;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_grant if_gnt=%b required 1", if_gnt);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    if_flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_memreq_pre mem_req=%b required 1", mem_req);
    end
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_memreq_ack mem_req=%b required 1", mem_req);
    end
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (if_rvalid === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop if_rvalid_pulses=%0d mem_req=%b required 0 0", cnt, mem_req);
    end
    rsp_data = 64'hAAAABBBB_00000517;
    sb.push_back('{is_if: 1'b1, data: rsp_data});
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h80000104;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_refetch if_gnt=%b required 1", if_gnt);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    drain("flush");
  endtask

  task automatic test_store();
    int nme, nif;
    ack_lat  = 1;
    rsp_data = 64'h0BADF00D_0BADF00D;
    sb.push_back('{is_if: 1'b0, data: rsp_data});
    @(posedge clk); #1;
    me_req = 1'b1; me_wen = 1'b1; me_addr = 64'h80002000;
    me_wdata = 64'h00000000_DEADBEEF; me_wmask = 8'h0F;
    @(negedge clk);
    n_checks++;
    if (me_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL store_grant me_gnt=%b if_gnt=%b required 1 0", me_gnt, if_gnt);
    end
    @(posedge clk); #1;
    me_req = 1'b0; me_wen = 1'b0; me_wdata = 64'd0; me_wmask = 8'd0; me_addr = 64'd0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 64'h80002000 ||
        mem_wdata !== 64'h00000000_DEADBEEF || mem_wmask !== 8'h0F) begin
      n_fail++;
      $display("FAIL store_fields req=%b wen=%b addr=%h wdata=%h wmask=%h required 1 1 80002000 00000000deadbeef 0f",
               mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask);
    end
    nme = 0; nif = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (me_rvalid === 1'b1) nme++;
      if (if_rvalid === 1'b1) nif++;
    end
    n_checks++;
    if (nme != 1 || nif != 0) begin
      n_fail++;
      $display("FAIL store_pulses me_rvalid=%0d if_rvalid=%0d required 1 0", nme, nif);
    end
    drain("store");
  endtask

  task automatic test_flush_idle();
    @(posedge clk); #1;
    if_req = 1'b1; if_flush = 1'b1; if_addr = 64'h80000200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (if_gnt !== 1'b0 || me_gnt !== 1'b0 || stall_if !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_idle cycle=%0d if_gnt=%b me_gnt=%b stall_if=%b mem_req=%b required 0 0 0 0",
                 c, if_gnt, me_gnt, stall_if, mem_req);
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0; if_flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cnt;
    auto_ack = 1'b0;
    mem_ack  = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h80000300;
    me_req = 1'b1; me_wen = 1'b0; me_addr = 64'h80003000;
    @(negedge clk);
    n_checks++;
    if (me_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_grant me_gnt=%b required 1", me_gnt);
    end
    @(posedge clk); #1;
    me_req = 1'b0; if_flush = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_memreq mem_req=%b required 0", mem_req);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 64'hCAFEBABE_CAFEBABE;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_rvalid === 1'b1 || me_rvalid === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0 || mem_req !== 1'b0 || me_rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL rstmid_late_ack rvalids=%0d mem_req=%b me_rdata=%h required 0 0 0", cnt, mem_req, me_rdata);
    end
    auto_ack = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_flush();
    test_store();
    test_flush_idle();
    test_reset_mid();
    test_contention();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required finish before 200000", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22041207_mem_arb.md
YSYX_22041207_MEM_ARB -- requirements
Module: ysyx_22041207_mem_arb

Interface
REQ-001 The block SHALL take one parameter, STARVE_MAX, default 3: the number of consecutive ME grants made while IF waits before IF is forced a grant.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 if_req  in  1  fetch request; held with if_addr until if_gnt or if_flush.
REQ-005 if_addr  in  64  fetch address.
REQ-006 if_flush  in  1  pipeline redirect; cancels pending or in-flight fetch.
REQ-007 if_gnt  out  1  fetch accepted this cycle.
REQ-008 if_rvalid  out  1  one-cycle pulse; if_rdata valid.
REQ-009 if_rdata  out  32  instruction, equal to mem_rdata[31:0].
REQ-010 stall_if  out  1  bubble to the fetch stage: if_req & ~if_gnt & ~if_flush.
REQ-011 me_req  in  1  load/store request; held with me_* until me_gnt.
REQ-012 me_wen  in  1  1 = store.
REQ-013 me_addr  in  64  data address.
REQ-014 me_wdata  in  64  store data.
REQ-015 me_wmask  in  8  byte enables.
REQ-016 me_gnt  out  1  data access accepted this cycle.
REQ-017 me_rvalid  out  1  one-cycle completion pulse, for loads and stores.
REQ-018 me_rdata  out  64  load data.
REQ-019 mem_req  out  1  memory request; held until mem_ack.
REQ-020 mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/64/64/8  latched request fields.
REQ-021 mem_ack  in  1  memory completion; mem_rdata valid this cycle.
REQ-022 mem_rdata  in  64  read data.

Function
REQ-023 States SHALL be IDLE, IF_WAIT and ME_WAIT; exactly one transaction is outstanding at a time.
REQ-024 IDLE arbitration:
- Grant ME when me_req=1, unless if_req=1 and starve_cnt==STARVE_MAX, in which case grant IF.
- Otherwise grant IF when if_req=1 and if_flush=0.
REQ-025 Grants SHALL be combinational and issued only in IDLE; the granted request fields SHALL be latched on that edge; the next state SHALL be IF_WAIT or ME_WAIT.
REQ-026 A granted IF access SHALL latch mem_wen=0 and mem_wmask=0.
REQ-027 mem_req SHALL be 1 throughout IF_WAIT and ME_WAIT, with mem_* fields stable, until the mem_ack cycle.
REQ-028 On mem_ack in a WAIT state:
- mem_rdata SHALL be latched into the owner's rdata register.
- The owner's rvalid SHALL pulse the following cycle.
- The state SHALL return to IDLE.
- Minimum latency: grant at cycle N, mem_req at N+1, rvalid at N+2.
REQ-029 starve_cnt counter:
- Increment, saturating at STARVE_MAX, on each ME grant while if_req=1.
- Clear on each IF grant.
- Hold otherwise.
REQ-030 if_flush in IDLE SHALL suppress IF grant that cycle.
REQ-031 if_flush during IF_WAIT, including the mem_ack cycle, SHALL set a drop flag; the memory transaction SHALL complete, if_rvalid SHALL stay 0, and the drop flag SHALL clear when the state returns to IDLE.
REQ-032 if_flush SHALL NOT affect ME transactions.
REQ-033 mem_ack in IDLE SHALL be ignored.
REQ-034 if_gnt and me_gnt SHALL never be 1 in the same cycle.
REQ-035 me_rdata and if_rdata SHALL hold their last value between pulses.

Reset
REQ-036 With rst_n=0 at a posedge:
- The state SHALL be IDLE.
- starve_cnt, drop flag, mem_req, both gnt and rvalid outputs, and all data/address outputs SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon it: mem_req SHALL be 0 from the next cycle, no rvalid SHALL pulse, and a late mem_ack SHALL be ignored.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x80000000, mem_ack 2 cycles after mem_req with mem_rdata=0x00000013_00100093 -> if_gnt at cycle 0; if_rvalid 1 cycle after ack; if_rdata=0x00100093.
REQ-039 Contention: if_req and me_req (load at 0x80001000) held continuously, 1-cycle ack -> grant order ME,ME,ME,IF (STARVE_MAX=3); stall_if=1 in every IDLE cycle without if_gnt.
REQ-040 Flush in flight: IF granted, if_flush=1 one cycle before mem_ack -> mem_req held until ack; if_rvalid never asserts; next fetch is granted normally.
REQ-041 Store: me_wen=1, me_addr=0x80002000, me_wdata=0xDEADBEEF, me_wmask=0x0F -> mem_* fields match; me_rvalid pulses once after ack; if_rvalid stays 0.
REQ-042 Reset mid-transaction: rst_n=0 during ME_WAIT, then mem_ack asserted the cycle after release -> mem_req=0; no rvalid; state IDLE; starve_cnt=0.
REQ-043 Simultaneous if_req and if_flush in IDLE with no me_req -> no grant; stall_if=0; mem_req stays 0.
